qeciphy_traffic_gen_chk: RTL and testbench

Link-test traffic source and sink for the QECIPHY example designs. It drives the QECIPHY TX AXI-Stream with a deterministic pattern and checks the QECIPHY RX AXI-Stream against the same pattern. The checker is self-synchronising, predicting each word from the previous received word, and keeps lock state, error statistics and a sticky error flag for LEDs and ILA probes. It replaces inline counter and check logic in board wrappers and sits in the ACLK domain, directly beside QECIPHY.

---
 rtl/qeciphy_traffic_gen_chk.sv | 196 +++++++++++++++++++
 tb/tb_qeciphy_traffic_gen_chk.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_traffic_gen_chk.sv
// qeciphy_traffic_gen_chk
// Link-test traffic source and sink that sits beside QECIPHY in the ACLK domain.
// The generator drives a deterministic pattern (incrementing or LFSR) on the
// TX AXI-Stream. The checker predicts each RX word from the previous RX word,
// so it synchronises to the stream by itself. It keeps lock state, a
// saturating error counter, a locked-beat counter and a sticky error flag.
//
// Ports
//   ACLK, rst_n          clock; asynchronous active-low reset
//   enable               level, allows TX traffic
//   link_up              level, QECIPHY link active
//   clear                1-cycle pulse, clears checker statistics and lock
//   tx_tdata/tvalid/tready  TX AXI-Stream (pattern source)
//   rx_tdata/tvalid/tready  RX AXI-Stream (rx_tready tied high)
//   locked               checker is in the LOCKED state
//   err_flag             sticky, set by any mismatch while locked
//   err_count            saturating count of mismatches while locked
//   word_count           count of RX beats accepted while locked (wraps)
module qeciphy_traffic_gen_chk #(
  parameter int DATA_W     = 64,
  parameter int PATTERN    = 0,
  parameter int LOCK_WORDS = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 ACLK,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 link_up,
  input  logic                 clear,
  output logic [DATA_W-1:0]    tx_tdata,
  output logic                 tx_tvalid,
  input  logic                 tx_tready,
  input  logic [DATA_W-1:0]    rx_tdata,
  input  logic                 rx_tvalid,
  output logic                 rx_tready,
  output logic                 locked,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          word_count
);

  localparam logic [DATA_W-1:0] TX_SEED = (PATTERN == 1) ? DATA_W'(1) : '0;
  localparam logic [3:0]        LOCK_N  = 4'(LOCK_WORDS);

  // Next word of the pattern. LFSR taps give x^64+x^63+x^61+x^60+1.
  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] w);
    if (PATTERN == 1)
      return {w[DATA_W-2:0], w[DATA_W-1] ^ w[DATA_W-2] ^ w[DATA_W-4] ^ w[DATA_W-5]};
    else
      return w + DATA_W'(1);
  endfunction

  // ---------------------------------------------------------------- generator
  logic              tx_tvalid_q, tx_tvalid_d;
  logic [DATA_W-1:0] tx_tdata_q,  tx_tdata_d;

  always_comb begin
    tx_tvalid_d = enable & link_up;
    // Advance only on an accepted beat so the sequence never skips or repeats.
    tx_tdata_d  = (tx_tvalid_q & tx_tready) ? step(tx_tdata_q) : tx_tdata_q;
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_tvalid_q <= 1'b0;
      tx_tdata_q  <= TX_SEED;
    end else begin
      tx_tvalid_q <= tx_tvalid_d;
      tx_tdata_q  <= tx_tdata_d;
    end
  end

  assign tx_tvalid = tx_tvalid_q;
  assign tx_tdata  = tx_tdata_q;

  // ---------------------------------------------------------------- checker
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [3:0]           run_cnt_q, run_cnt_d;
  logic                 has_prev_q, has_prev_d;
  logic [DATA_W-1:0]    prev_q, prev_d;
  logic                 err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [31:0]          word_count_q, word_count_d;

  logic       flush;      // drop sync: clear or link down
  logic       cmp;        // beat that is compared against the prediction
  logic       match;
  logic       cnt_word;   // compared beat while locked
  logic       cnt_err;    // mismatching beat while locked
  logic [3:0] run_inc;
  logic       run_hit;

  assign rx_tready = 1'b1;
  assign flush     = clear | ~link_up;
  assign cmp       = rx_tvalid & has_prev_q & ~flush;
  // An all-zero word is the LFSR lock-up state and can never be legal.
  assign match     = (rx_tdata == step(prev_q)) &&
                     ((PATTERN != 1) || (rx_tdata != '0));
  assign run_inc   = run_cnt_q + 4'd1;
  assign run_hit   = (run_inc == LOCK_N);

  // State register
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Next-state logic: run_cnt counts matches in HUNT, mismatches in LOCKED.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    if (flush) begin
      state_d   = HUNT;
      run_cnt_d = '0;
    end else if (cmp) begin
      case (state_q)
        HUNT: begin
          if (!match)       run_cnt_d = '0;
          else if (run_hit) begin state_d = LOCKED; run_cnt_d = '0; end
          else              run_cnt_d = run_inc;
        end
        LOCKED: begin
          if (match)        run_cnt_d = '0;
          else if (run_hit) begin state_d = HUNT; run_cnt_d = '0; end
          else              run_cnt_d = run_inc;
        end
        default: begin
          state_d   = HUNT;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    locked   = (state_q == LOCKED);
    cnt_word = cmp & (state_q == LOCKED);
    cnt_err  = cnt_word & ~match;
  end

  // Prediction history and statistics
  always_comb begin
    has_prev_d   = has_prev_q;
    prev_d       = prev_q;
    err_flag_d   = err_flag_q;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;
    if (flush) begin
      // A beat coinciding with clear or link down is discarded.
      has_prev_d = 1'b0;
    end else if (rx_tvalid) begin
      has_prev_d = 1'b1;
      prev_d     = rx_tdata;
    end
    if (clear) begin
      err_flag_d   = 1'b0;
      err_count_d  = '0;
      word_count_d = '0;
    end else begin
      if (cnt_word) word_count_d = word_count_q + 32'd1;
      if (cnt_err) begin
        err_flag_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      has_prev_q   <= 1'b0;
      prev_q       <= '0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      has_prev_q   <= has_prev_d;
      prev_q       <= prev_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_qeciphy_traffic_gen_chk.sv
// Directed bench: u0 is an incrementing-pattern instance in TX->RX loopback,
// u1 is an LFSR instance with a 4-bit error counter whose RX side is driven
// directly with hand-built sequences.
module tb_qeciphy_traffic_gen_chk;

  logic        ACLK = 1'b0;
  logic        rst_n;
  logic        enable, link_up;
  logic        clr0, clr1;

  logic [63:0] tx_tdata0;
  logic        tx_tvalid0, tx_tready0;
  logic [63:0] rx_tdata0;
  logic        rx_tvalid0, rx_tready0;
  logic        locked0, err_flag0;
  logic [15:0] err_count0;
  logic [31:0] word_count0;

  logic [63:0] tx_tdata1;
  logic        tx_tvalid1, tx_tready1;
  logic [63:0] rx_tdata1;
  logic        rx_tvalid1, rx_tready1;
  logic        locked1, err_flag1;
  logic [3:0]  err_count1;
  logic [31:0] word_count1;

  int checks = 0;
  int fails  = 0;
  logic [63:0] lf;

  always #5 ACLK = ~ACLK;

  // Loopback: an RX beat exists exactly when a TX beat is accepted.
  assign rx_tdata0  = tx_tdata0;
  assign rx_tvalid0 = tx_tvalid0 & tx_tready0;

  qeciphy_traffic_gen_chk #(.DATA_W(64), .PATTERN(0), .LOCK_WORDS(4), .ERR_CNT_W(16)) u0 (
    .ACLK(ACLK), .rst_n(rst_n), .enable(enable), .link_up(link_up), .clear(clr0),
    .tx_tdata(tx_tdata0), .tx_tvalid(tx_tvalid0), .tx_tready(tx_tready0),
    .rx_tdata(rx_tdata0), .rx_tvalid(rx_tvalid0), .rx_tready(rx_tready0),
    .locked(locked0), .err_flag(err_flag0), .err_count(err_count0), .word_count(word_count0));

  qeciphy_traffic_gen_chk #(.DATA_W(64), .PATTERN(1), .LOCK_WORDS(4), .ERR_CNT_W(4)) u1 (
    .ACLK(ACLK), .rst_n(rst_n), .enable(enable), .link_up(link_up), .clear(clr1),
    .tx_tdata(tx_tdata1), .tx_tvalid(tx_tvalid1), .tx_tready(tx_tready1),
    .rx_tdata(rx_tdata1), .rx_tvalid(rx_tvalid1), .rx_tready(rx_tready1),
    .locked(locked1), .err_flag(err_flag1), .err_count(err_count1), .word_count(word_count1));

  function automatic logic [63:0] lstep(input logic [63:0] w);
    return {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic [63:0] d);
    rx_tdata1  = d;
    rx_tvalid1 = 1'b1;
    tick();
  endtask

  // Corrupt one word of the true LFSR stream, then continue the true stream.
  task automatic corrupt_triple();
    lf = lstep(lf); send1(lf ^ 64'h20);
    lf = lstep(lf); send1(lf);
    lf = lstep(lf); send1(lf);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; link_up = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    tx_tready0 = 1'b1; tx_tready1 = 1'b0;
    rx_tdata1 = '0; rx_tvalid1 = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_tvalid0", 64'(tx_tvalid0), 64'd0);
    chk("rst_tdata0",  tx_tdata0, 64'd0);
    chk("rst_locked0", 64'(locked0), 64'd0);
    chk("rst_err0",    64'(err_count0), 64'd0);
    chk("rst_wc0",     64'(word_count0), 64'd0);
    chk("rst_flag0",   64'(err_flag0), 64'd0);
    chk("rst_tdata1",  tx_tdata1, 64'd1);
    chk("rx_tready0",  64'(rx_tready0), 64'd1);

    rst_n = 1'b1;
    tick();
    enable = 1'b1; link_up = 1'b1;
    chk("tvalid_pre", 64'(tx_tvalid0), 64'd0);
    tick();
    chk("tvalid_on", 64'(tx_tvalid0), 64'd1);
    chk("tdata_first", tx_tdata0, 64'd0);

    // Clean loopback: beats 0..3 leave it hunting, beat 4 locks
    repeat (4) tick();
    chk("hunt_after4", 64'(locked0), 64'd0);
    tick();
    chk("lock_after5", 64'(locked0), 64'd1);
    chk("wc_at_lock",  64'(word_count0), 64'd0);
    chk("tdata_5",     tx_tdata0, 64'd5);
    repeat (2) tick();
    chk("wc_2",    64'(word_count0), 64'd2);
    chk("tdata_7", tx_tdata0, 64'd7);

    // Backpressure while tx_tdata = 7
    tx_tready0 = 1'b0;
    repeat (3) tick();
    chk("bp_hold7", tx_tdata0, 64'd7);
    chk("bp_wc",    64'(word_count0), 64'd2);
    tx_tready0 = 1'b1;
    tick();
    chk("bp_wc3",  64'(word_count0), 64'd3);
    chk("bp_next", tx_tdata0, 64'd8);
    repeat (2) tick();
    chk("bp_wc5",     64'(word_count0), 64'd5);
    chk("bp_tdata10", tx_tdata0, 64'd10);
    chk("bp_err",     64'(err_count0), 64'd0);
    chk("bp_flag",    64'(err_flag0), 64'd0);
    chk("bp_locked",  64'(locked0), 64'd1);

    // enable drop: the beat already valid is taken, then valid falls
    enable = 1'b0;
    tick();
    chk("en_off_tvalid", 64'(tx_tvalid0), 64'd0);
    chk("en_off_tdata",  tx_tdata0, 64'd11);
    chk("en_off_wc",     64'(word_count0), 64'd6);
    tick();
    chk("en_off_hold", tx_tdata0, 64'd11);
    enable = 1'b1;
    tick();
    tick();
    chk("resume_wc",  64'(word_count0), 64'd7);
    chk("resume_err", 64'(err_count0), 64'd0);

    // link_up low: drop lock, keep statistics
    link_up = 1'b0;
    tick();
    chk("ld_locked", 64'(locked0), 64'd0);
    chk("ld_wc",     64'(word_count0), 64'd7);
    chk("ld_tvalid", 64'(tx_tvalid0), 64'd0);
    link_up = 1'b1;
    repeat (6) tick();
    chk("relock0",    64'(locked0), 64'd1);
    chk("relock_wc",  64'(word_count0), 64'd7);
    chk("relock_err", 64'(err_count0), 64'd0);

    // LFSR generator: 1 -> 2 -> 4 -> 8
    chk("lfsr_hold", tx_tdata1, 64'd1);
    tx_tready1 = 1'b1;
    repeat (3) tick();
    tx_tready1 = 1'b0;
    chk("lfsr_tx3", tx_tdata1, 64'd8);

    // LFSR checker lock
    lf = 64'h1234_5678_9ABC_DEF1;
    send1(lf);
    repeat (3) begin lf = lstep(lf); send1(lf); end
    chk("l_hunt", 64'(locked1), 64'd0);
    lf = lstep(lf); send1(lf);
    chk("l_lock", 64'(locked1), 64'd1);
    chk("l_err0", 64'(err_count1), 64'd0);

    // Single bit-5 error gives two mismatches
    lf = lstep(lf); send1(lf ^ 64'h20);
    chk("sb_err1", 64'(err_count1), 64'd1);
    lf = lstep(lf); send1(lf);
    lf = lstep(lf); send1(lf);
    chk("sb_err2",  64'(err_count1), 64'd2);
    chk("sb_flag",  64'(err_flag1), 64'd1);
    chk("sb_lock",  64'(locked1), 64'd1);
    chk("sb_wc",    64'(word_count1), 64'd3);

    // Loss of lock; the second zero equals step(0) but zero is always bad
    send1(64'hDEAD_BEEF_CAFE_F00D);
    send1(64'h0);
    send1(64'h0);
    chk("ll_still", 64'(locked1), 64'd1);
    chk("ll_err5",  64'(err_count1), 64'd5);
    send1(64'hAAAA_AAAA_AAAA_AAAA);
    chk("ll_drop", 64'(locked1), 64'd0);
    chk("ll_err6", 64'(err_count1), 64'd6);
    chk("ll_wc",   64'(word_count1), 64'd7);
    lf = 64'h0123_4567_89AB_CDEF;
    send1(lf);
    repeat (3) begin lf = lstep(lf); send1(lf); end
    chk("ll_hunt", 64'(locked1), 64'd0);
    lf = lstep(lf); send1(lf);
    chk("ll_relock", 64'(locked1), 64'd1);
    chk("ll_err_hold", 64'(err_count1), 64'd6);

    // Saturation of the 4-bit error counter
    repeat (4) corrupt_triple();
    chk("sat_14", 64'(err_count1), 64'd14);
    repeat (6) corrupt_triple();
    chk("sat_15",   64'(err_count1), 64'd15);
    chk("sat_lock", 64'(locked1), 64'd1);
    chk("sat_wc",   64'(word_count1), 64'd37);

    // Clear with a simultaneous beat: the beat is discarded
    lf = lstep(lf);
    rx_tdata1 = lf; rx_tvalid1 = 1'b1; clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("clr_err",  64'(err_count1), 64'd0);
    chk("clr_flag", 64'(err_flag1), 64'd0);
    chk("clr_wc",   64'(word_count1), 64'd0);
    chk("clr_lock", 64'(locked1), 64'd0);
    repeat (4) begin lf = lstep(lf); send1(lf); end
    chk("clr_nostore", 64'(locked1), 64'd0);
    lf = lstep(lf); send1(lf);
    chk("clr_relock", 64'(locked1), 64'd1);
    rx_tvalid1 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
